grid_update_ctrl: RTL and testbench

GRID_UPDATE_CTRL -- requirements
Module: grid_update_ctrl

---
 rtl/grid_pkg.sv | 18 +
 rtl/rr_arb2.sv | 38 +++
 rtl/grid_update_ctrl.sv | 143 ++++++++++++++
 tb/tb_grid_update_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared types and constants for the 4x4 colour grid controller.
// Arbitration mode is selected by GRID_RR_ARB_EN (see rr_arb2).
package grid_pkg;

    localparam int GRID_ROWS  = 4;
    localparam int GRID_COLS  = 4;
    localparam int GRID_CELLS = 16;

    typedef logic [11:0] color_t;
    typedef logic [3:0]  cell_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester write arbiter for the grid shadow array.
// GRID_RR_ARB_EN defined: round-robin; undefined: A has fixed priority.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

`ifdef GRID_RR_ARB_EN
    logic last_b;
    logic pick_a;

    assign pick_a = req_a & (~req_b | last_b);
    assign gnt_a  = en & pick_a;
    assign gnt_b  = en & req_b & ~pick_a;

    // Remember who was served last; starts at B so A wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_b <= 1'b1;
        else if (gnt_a)
            last_b <= 1'b0;
        else if (gnt_b)
            last_b <= 1'b1;
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ reset;
    assign gnt_a = en & req_a;
    assign gnt_b = en & req_b & ~req_a;
`endif

endmodule

// File: rtl/grid_update_ctrl.sv
// Double-buffered 4x4 colour grid: requesters write a shadow copy,
// committed to the displayed grid in vertical blanking. Uses GRID_RR_ARB_EN.
import grid_pkg::*;

module grid_update_ctrl #(
    parameter color_t CLEAR_COLOR = 12'h000,
    parameter color_t RESET_COLOR = 12'h606
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [3:0]  addr_a,
    input  logic [3:0]  addr_b,
    input  logic [11:0] data_a,
    input  logic [11:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    input  logic        clear_req,
    input  logic        err_clr,
    output logic [47:0] x1,
    output logic [47:0] x2,
    output logic [47:0] x3,
    output logic [47:0] x4,
    output logic        busy,
    output logic        error
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] CLEAR  = ST_CLEAR;
    localparam logic [1:0] COMMIT = ST_COMMIT;

    logic [1:0] state;
    color_t     shadow [GRID_CELLS];
    color_t     active [GRID_CELLS];
    logic       dirty;
    cell_idx_t  cnt;

    logic       idle;
    logic       go_clear;
    logic       go_commit;
    logic       arb_en;
    logic       err_set;
    logic       wr_en;
    cell_idx_t  wr_addr;
    color_t     wr_data;

    assign idle      = (state == IDLE);
    assign go_clear  = idle & clear_req;
    assign go_commit = idle & ~clear_req & frame_start & dirty;
    assign arb_en    = idle & ~reset & ~clear_req & ~(frame_start & dirty);
    assign err_set   = frame_start & (~idle | clear_req);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign wr_en   = gnt_a | gnt_b;
    assign wr_addr = gnt_a ? addr_a : addr_b;
    assign wr_data = gnt_a ? data_a : data_b;

    // Sequencer: idle / 16-cycle clear sweep / single-cycle commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dirty <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else if (go_commit) begin
                        state <= COMMIT;
                    end else if (wr_en) begin
                        dirty <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        dirty <= 1'b1;
                        state <= IDLE;
                    end
                end
                COMMIT: begin
                    dirty <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow array: clear sweep owns the write port while sweeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < GRID_CELLS; i++)
                shadow[i] <= RESET_COLOR;
        end else if (state == CLEAR) begin
            shadow[cnt] <= CLEAR_COLOR;
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Active array: whole-grid copy on the commit edge only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < GRID_CELLS; i++)
                active[i] <= RESET_COLOR;
        end else if (state == COMMIT) begin
            for (int i = 0; i < GRID_CELLS; i++)
                active[i] <= shadow[i];
        end
    end

    // Sticky missed-commit flag; a new set beats err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            error <= 1'b0;
        else if (err_set)
            error <= 1'b1;
        else if (err_clr)
            error <= 1'b0;
    end

    assign busy = ~idle;

    assign x1 = {active[3],  active[2],  active[1],  active[0]};
    assign x2 = {active[7],  active[6],  active[5],  active[4]};
    assign x3 = {active[11], active[10], active[9],  active[8]};
    assign x4 = {active[15], active[14], active[13], active[12]};

endmodule

// File: tb/tb_grid_update_ctrl.sv
// Directed bench for grid_update_ctrl (both GRID_RR_ARB_EN builds).
module tb_grid_update_ctrl;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        req_a, req_b;
    logic [3:0]  addr_a, addr_b;
    logic [11:0] data_a, data_b;
    logic        gnt_a, gnt_b;
    logic        clear_req, err_clr;
    logic [47:0] x1, x2, x3, x4;
    logic        busy, error;

    int n_vec;
    int n_bad;
    int busy_n;

    localparam logic [47:0] ROW606 = {4{12'h606}};
    localparam logic [47:0] X2B70  = {12'h606, 12'h606, 12'hB70, 12'h606};

`ifdef GRID_RR_ARB_EN
    localparam logic [3:0]  EXP_A  = 4'b0101;
    localparam logic [3:0]  EXP_B  = 4'b1010;
    localparam logic [47:0] X1ARB  = {12'h606, 12'h606, 12'h222, 12'h111};
`else
    localparam logic [3:0]  EXP_A  = 4'b1111;
    localparam logic [3:0]  EXP_B  = 4'b0000;
    localparam logic [47:0] X1ARB  = {12'h606, 12'h606, 12'h606, 12'h111};
`endif

    logic [3:0] exp_a;
    logic [3:0] exp_b;

    grid_update_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .req_a       (req_a),
        .req_b       (req_b),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .data_a      (data_a),
        .data_b      (data_b),
        .gnt_a       (gnt_a),
        .gnt_b       (gnt_b),
        .clear_req   (clear_req),
        .err_clr     (err_clr),
        .x1          (x1),
        .x2          (x2),
        .x3          (x3),
        .x4          (x4),
        .busy        (busy),
        .error       (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        exp_a = EXP_A;
        exp_b = EXP_B;
        reset = 1'b0;
        frame_start = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        addr_a = '0; addr_b = '0;
        data_a = '0; data_b = '0;
        clear_req = 1'b0; err_clr = 1'b0;

        // reset state
        #2;
        reset = 1'b1;
        req_a = 1'b1;
        #1;
        chk("rst_x1", x1, ROW606);
        chk("rst_x4", x4, ROW606);
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_error", {47'd0, error}, 48'd0);
        chk("rst_gnt_a", {47'd0, gnt_a}, 48'd0);
        req_a = 1'b0;
        step();
        step();
        reset = 1'b0;

        // arbitration with both requesters held 4 cycles
        req_a = 1'b1; addr_a = 4'd0; data_a = 12'h111;
        req_b = 1'b1; addr_b = 4'd1; data_b = 12'h222;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("arb_gnt_a", {47'd0, gnt_a}, {47'd0, exp_a[i]});
            chk("arb_gnt_b", {47'd0, gnt_b}, {47'd0, exp_b[i]});
            step();
        end
        req_a = 1'b0; req_b = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("arb_x1", x1, X1ARB);
        chk("arb_error", {47'd0, error}, 48'd0);

        // fresh reset, single write then commit
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req_a = 1'b1; addr_a = 4'd5; data_a = 12'hB70;
        #1;
        chk("wr_gnt_a", {47'd0, gnt_a}, 48'd1);
        step();
        req_a = 1'b0;
        frame_start = 1'b1;
        #1;
        chk("fs_busy", {47'd0, busy}, 48'd0);
        step();
        frame_start = 1'b0;
        chk("commit_busy", {47'd0, busy}, 48'd1);
        chk("commit_x2_pre", x2, ROW606);
        step();
        chk("commit_x2", x2, X2B70);
        chk("commit_x1", x1, ROW606);
        chk("commit_x3", x3, ROW606);
        chk("commit_x4", x4, ROW606);
        chk("commit_done", {47'd0, busy}, 48'd0);

        // clear sweep with a frame_start landing mid-sweep
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            frame_start = (i == 5);
            #1;
            if (busy) busy_n++;
            step();
        end
        frame_start = 1'b0;
        chk("clr_busy_cycles", 48'(busy_n), 48'd16);
        chk("clr_error", {47'd0, error}, 48'd1);
        chk("clr_x1_hold", x1, ROW606);
        chk("clr_x2_hold", x2, X2B70);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("clr_x1", x1, 48'd0);
        chk("clr_x2", x2, 48'd0);
        chk("clr_x3", x3, 48'd0);
        chk("clr_x4", x4, 48'd0);
        chk("clr_err_sticky", {47'd0, error}, 48'd1);

        // err_clr colliding with a new set during CLEAR
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        step();
        frame_start = 1'b1;
        err_clr = 1'b1;
        step();
        frame_start = 1'b0;
        err_clr = 1'b0;
        chk("errclr_vs_set", {47'd0, error}, 48'd1);
        for (int i = 0; i < 40 && busy; i++) step();
        chk("clear_done", {47'd0, busy}, 48'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr", {47'd0, error}, 48'd0);

        // B request arriving in the COMMIT cycle
        req_a = 1'b1; addr_a = 4'd2; data_a = 12'hABC;
        #1;
        chk("c37_gnt_a", {47'd0, gnt_a}, 48'd1);
        step();
        req_a = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req_b = 1'b1; addr_b = 4'd3; data_b = 12'hDEF;
        #1;
        chk("c37_gnt_b_commit", {47'd0, gnt_b}, 48'd0);
        chk("c37_busy", {47'd0, busy}, 48'd1);
        step();
        chk("c37_gnt_b_idle", {47'd0, gnt_b}, 48'd1);
        step();
        req_b = 1'b0;
        chk("c37_x1_pre", x1, {12'h000, 12'hABC, 24'h0});
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("c37_x1_post", x1, {12'hDEF, 12'hABC, 24'h0});

        // reset in the middle of a clear sweep
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (7) step();
        #2;
        reset = 1'b1;
        #1;
        chk("midclr_x1", x1, ROW606);
        chk("midclr_x3", x3, ROW606);
        chk("midclr_busy", {47'd0, busy}, 48'd0);
        chk("midclr_error", {47'd0, error}, 48'd0);
        reset = 1'b0;
        step();
        frame_start = 1'b1;
        #1;
        chk("nodirty_busy0", {47'd0, busy}, 48'd0);
        step();
        frame_start = 1'b0;
        chk("nodirty_busy1", {47'd0, busy}, 48'd0);
        step();
        chk("nodirty_x1", x1, ROW606);
        chk("nodirty_error", {47'd0, error}, 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
